// File: rtl/miriscv_mem_arbiter.sv
// Shared memory port arbiter for fetch and LSU requests.
// In-order response routing through a small owner-ID FIFO.
module miriscv_mem_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  logic [OUTSTANDING-1:0] ids;
  logic [PW-1:0]          wptr;
  logic [PW-1:0]          rptr;
  logic [CW-1:0]          count;
  logic [3:0]             starve;
  logic                   locked;
  owner_e                 lock_owner;
  owner_e                 owner;
  logic                   room;
  logic                   push;
  logic                   pop;
  logic                   head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Held owner wins over priority so a stalled request never changes shape.
  always_comb begin
    owner = OWN_DATA;
    if (locked)
      owner = lock_owner;
    else if (instr_req_i && data_req_i)
      owner = (starve == 4'(STARVE_LIMIT)) ? OWN_INSTR : OWN_DATA;
    else if (instr_req_i)
      owner = OWN_INSTR;
  end

  assign room      = count < CW'(OUTSTANDING);
  assign mem_req_o = arstn_i & (instr_req_i | data_req_i) & room;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (arstn_i) begin
      if (owner == OWN_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign push        = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = push & (owner == OWN_INSTR);
  assign data_gnt_o  = push & (owner == OWN_DATA);

  assign pop  = arstn_i & mem_rvalid_i & (count != '0);
  assign head = ids[rptr];

  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ids        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      starve     <= '0;
      locked     <= 1'b0;
      lock_owner <= OWN_DATA;
    end else begin
      if (push) begin
        ids[wptr] <= owner;
        wptr      <= inc(wptr);
      end
      if (pop)
        rptr <= inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      locked     <= mem_req_o & ~mem_gnt_i;
      lock_owner <= owner;
      if (instr_gnt_o || !instr_req_i)
        starve <= '0;
      else if (starve != 4'(STARVE_LIMIT))
        starve <= starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter.
// Responses are checked by a queue-based monitor.
module tb_miriscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  miriscv_mem_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] IA = 32'h1000_0040;
  localparam logic [31:0] DA = 32'h2000_0080;
  localparam logic [31:0] DW = 32'hCAFE_F00D;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  logic exp_now;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected entry.
  always @(negedge clk_i) begin
    rsp_t e;
    if (instr_rvalid_o || data_rvalid_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rvalid: got i=%b d=%b want none",
                 instr_rvalid_o, data_rvalid_o);
      end else begin
        e = exp_q.pop_front();
        if ({data_rvalid_o, instr_rvalid_o} !== {e.is_data, !e.is_data} ||
            instr_rdata_o !== e.rdata || data_rdata_o !== e.rdata) begin
          fails++;
          $display("FAIL rsp_route: got d=%b i=%b rd=%h want d=%b rd=%h",
                   data_rvalid_o, instr_rvalid_o, data_rdata_o,
                   e.is_data, e.rdata);
        end
      end
    end else if (exp_now) begin
      tests++;
      fails++;
      $display("FAIL missing_rvalid: got none want d=%b",
               exp_q[0].is_data);
      void'(exp_q.pop_front());
    end
  end

  task automatic next();
    @(posedge clk_i);
    #1;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    exp_now      = 1'b0;
  endtask

  task automatic rsp(input logic is_data, input logic [31:0] d);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    exp_q.push_back('{is_data: is_data, rdata: d});
    exp_now = 1'b1;
  endtask

  task automatic gnts(input string n, input logic i, input logic d);
    #2;
    chk({n, "_igt"}, 32'(instr_gnt_o), 32'(i));
    chk({n, "_dgt"}, 32'(data_gnt_o), 32'(d));
  endtask

  initial begin
    arstn_i      = 1'b0;
    instr_req_i  = 1'b1;
    instr_addr_i = IA;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    data_addr_i  = DA;
    data_wdata_i = DW;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1;
    exp_now      = 1'b0;
    #3;
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, 0);
    next();
    next();
    arstn_i = 1'b1;

    // Simultaneous requests with fresh starve counter: data wins.
    next();
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    gnts("both", 1'b0, 1'b1);
    chk("both_addr", mem_addr_o, DA);
    chk("both_we", 32'(mem_we_o), 1);
    chk("both_be", 32'(mem_be_o), 32'h3);
    chk("both_wd", mem_wdata_o, DW);
    next();
    rsp(1'b1, 32'hD000_0001);

    // Starvation: four data grants, then instr on the fifth cycle.
    for (int c = 1; c <= 5; c++) begin
      next();
      instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
      if (c == 1) mem_rvalid_i = 1'b1;
      else rsp(1'b1, 32'hD100_0000 + 32'(c));
      gnts($sformatf("starve%0d", c), c == 5, c != 5);
    end
    chk("starve_addr", mem_addr_o, IA);
    chk("starve_fetch", {mem_we_o, mem_be_o, mem_wdata_o[26:0]}, 32'hF << 27);
    next();
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    rsp(1'b0, 32'hA100_0005);
    gnts("starve_clr", 1'b0, 1'b1);
    next();
    rsp(1'b1, 32'hD100_0006);

    // Lock: instr stalled three cycles while data rises.
    next();
    instr_req_i = 1'b1;
    gnts("lock1", 1'b0, 1'b0);
    for (int c = 2; c <= 3; c++) begin
      next();
      instr_req_i = 1'b1; data_req_i = 1'b1;
      gnts($sformatf("lock%0d", c), 1'b0, 1'b0);
      chk($sformatf("lock%0d_addr", c), mem_addr_o, IA);
    end
    next();
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    gnts("lock_rel", 1'b1, 1'b0);
    next();
    data_req_i = 1'b1; mem_gnt_i = 1'b1;
    gnts("fill2", 1'b0, 1'b1);

    // FIFO full: no request until a response frees a slot.
    next();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    #2 chk("full_req", 32'(mem_req_o), 0);
    next();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    rsp(1'b0, 32'hA200_0001);
    gnts("full_pop", 1'b0, 1'b0);
    next();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    rsp(1'b1, 32'hD200_0002);
    gnts("push_pop", 1'b1, 1'b0);
    next();
    rsp(1'b0, 32'hA200_0003);

    // Reset with two pending: late responses are dropped.
    next();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    gnts("pre_rst_i", 1'b1, 1'b0);
    next();
    data_req_i = 1'b1; mem_gnt_i = 1'b1;
    gnts("pre_rst_d", 1'b0, 1'b1);
    next();
    arstn_i = 1'b0;
    instr_req_i = 1'b1;
    #2 chk("mid_rst_req", 32'(mem_req_o), 0);
    next();
    arstn_i = 1'b1;
    mem_rvalid_i = 1'b1;
    #2 chk("drop_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, 0);
    next();
    data_req_i = 1'b1; mem_gnt_i = 1'b1;
    gnts("post_rst_d", 1'b0, 1'b1);
    next();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    gnts("post_rst_i", 1'b1, 1'b0);
    next();
    rsp(1'b1, 32'hD300_0001);
    next();
    rsp(1'b0, 32'hA300_0002);
    next();
    next();
    chk("q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/miriscv_mem_arbiter.md
MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 Parameter OUTSTANDING, default 2, max accepted-but-unanswered memory transactions (1..4).
REQ-002 Parameter STARVE_LIMIT, default 4, cycles a waiting fetch may be bypassed before it wins priority (1..15).
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 arstn_i  in  1  reset, asynchronous assert, active-low.
REQ-005 instr_req_i  in  1  fetch request; instr_addr_i  in  32  fetch address.
REQ-006 instr_gnt_o  out  1  fetch accepted; instr_rvalid_o  out  1  fetch response; instr_rdata_o  out  32  fetch data.
REQ-007 data_req_i  in  1  LSU request; data_we_i  in  1  write; data_be_i  in  4  byte enables; data_addr_i  in  32; data_wdata_i  in  32.
REQ-008 data_gnt_o  out  1  LSU accepted; data_rvalid_o  out  1  LSU response; data_rdata_o  out  32  LSU data.
REQ-009 mem_req_o  out  1; mem_we_o  out  1; mem_be_o  out  4; mem_addr_o  out  32; mem_wdata_o  out  32  shared port request.
REQ-010 mem_gnt_i  in  1  port accepted; mem_rvalid_i  in  1  port response (reads and writes); mem_rdata_i  in  32.

Function
REQ-011 Requesters hold req and all fields stable until gnt; arbiter relies on it.
REQ-012 Owner selection: data wins by default; instr wins when starve counter == STARVE_LIMIT; one requester only -> that requester.
REQ-013 Lock: once mem_req_o asserted without mem_gnt_i, owner held (no switching) until mem_gnt_i.
REQ-014 mem_* fields are combinational mux of owner's inputs; fetch drives mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-015 mem_req_o = (instr_req_i | data_req_i) & (outstanding count < OUTSTANDING).
REQ-016 x_gnt_o = mem_gnt_i & mem_req_o & (owner == x); never both gnts same cycle.
REQ-017 On grant, owner ID (0=instr,1=data) pushed into in-order ID FIFO, depth OUTSTANDING.
REQ-018 On mem_rvalid_i with FIFO non-empty: route to head ID's x_rvalid_o same cycle (combinational), pop head.
REQ-019 instr_rdata_o and data_rdata_o both = mem_rdata_i unconditionally.
REQ-020 Grant and rvalid same cycle: push and pop both; count unchanged; response goes to pre-push head.
REQ-021 mem_rvalid_i with FIFO empty: ignored, no rvalid out, no state change.
REQ-022 FIFO full: mem_req_o=0, no gnt; rvalid-pop frees slot for next cycle's request.
REQ-023 Starve counter: +1 each cycle instr_req_i=1 and instr_gnt_o=0, saturates at STARVE_LIMIT; clears on instr_gnt_o or when instr_req_i=0.
REQ-024 Zero added latency: request to mem_req_o combinational, rvalid to x_rvalid_o combinational.
REQ-025 FIFO pointers wrap modulo OUTSTANDING; count width $clog2(OUTSTANDING+1).

Reset
REQ-026 arstn_i low: FIFO empty, pointers/count 0, starve counter 0, lock cleared, immediately.
REQ-027 During reset all outputs driven 0 (mem_req_o, gnts, rvalids=0).
REQ-028 Reset mid-transaction: pending IDs discarded; post-reset rvalid dropped per REQ-021.

Verification
REQ-029 Both req same cycle, mem_gnt_i=1, counter 0 -> data_gnt_o=1, mem_addr_o=data_addr_i, instr_gnt_o=0.
REQ-030 data_req_i held 5 cycles with instr_req_i, gnt every cycle, rvalid every cycle, STARVE_LIMIT=4 -> cycles 1-4 data granted, cycle 5 instr granted, counter cleared.
REQ-031 Instr owns, mem_gnt_i=0 3 cycles, data_req_i rises cycle 2 -> owner stays instr until gnt; mem_addr_o stable.
REQ-032 Two grants (instr then data), no rvalid -> count 2, mem_req_o=0; rvalids then route instr_rvalid_o, data_rvalid_o in order.
REQ-033 Count 1 (data pending), same cycle instr gnt + mem_rvalid_i -> data_rvalid_o=1, count stays 1, head now instr.
REQ-034 Count 2, arstn_i low 1 cycle, then mem_rvalid_i=1 -> no x_rvalid_o, count 0, new requests granted.
